// File: rtl/fifo_drain.sv
// fifo_drain: pops the FIFO read port into a 2-entry buffer and presents a valid/ready burst stream.
// Define FIFO_DRAIN_PARITY_EN to add out_parity (even parity of out_data).
module fifo_drain #(
    parameter int N = 8,
    parameter int BURST = 4,
    localparam int CW = BURST > 1 ? $clog2(BURST) : 1
) (
    input  logic          clk,
    input  logic          arst,
    input  logic          en,
    input  logic          fifo_empty,
    output logic          fifo_r_en,
    input  logic [N-1:0]  fifo_rdata,
    output logic [N-1:0]  out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic [CW-1:0] beat_cnt,
    output logic          busy
`ifdef FIFO_DRAIN_PARITY_EN
    ,
    output logic          out_parity
`endif
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t state, state_nx;
    logic [1:0] occ, room;
    logic inflight, xfer;
    logic [N-1:0] slot0, slot1;
    assign out_valid = occ != 2'd0;
    assign xfer = out_valid & out_ready;
    // Occupancy after this cycle's transfer; counting the freed slot keeps pops back-to-back.
    assign room = occ - {1'b0, xfer};
    assign out_data = slot0;
    assign out_last = out_valid && beat_cnt == CW'(BURST - 1);
    assign busy = state != IDLE;
    always_comb begin
        state_nx = state;
        fifo_r_en = 1'b0;
        case (state)
            IDLE: state_nx = en ? RUN : IDLE;
            RUN: begin
                fifo_r_en = !arst && !fifo_empty && (room + {1'b0, inflight}) < 2'd2;
                state_nx = en ? RUN : DRAIN;
            end
            DRAIN: state_nx = en ? RUN : (occ == 2'd0 && !inflight) ? IDLE : DRAIN;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (arst) begin
            state <= IDLE;
            occ <= 2'd0;
            inflight <= 1'b0;
            slot0 <= '0;
            slot1 <= '0;
            beat_cnt <= '0;
        end else begin
            state <= state_nx;
            inflight <= fifo_r_en;
            occ <= room + {1'b0, inflight};
            if (xfer) begin
                slot0 <= slot1;
                beat_cnt <= beat_cnt == CW'(BURST - 1) ? '0 : beat_cnt + 1'b1;
            end
            if (inflight) begin
                if (room == 2'd0) slot0 <= fifo_rdata;
                else slot1 <= fifo_rdata;
            end
        end
    end
`ifdef FIFO_DRAIN_PARITY_EN
    logic par0, par1;
    assign out_parity = par0;
    always_ff @(posedge clk) begin
        if (arst) begin
            par0 <= 1'b0;
            par1 <= 1'b0;
        end else begin
            if (xfer) par0 <= par1;
            if (inflight) begin
                if (room == 2'd0) par0 <= ^fifo_rdata;
                else par1 <= ^fifo_rdata;
            end
        end
    end
`endif
endmodule

// File: tb/tb_fifo_drain.sv
// tb_fifo_drain: FIFO model + scoreboard bench for fifo_drain (N=8, BURST=4).
module tb_fifo_drain;
    localparam int BURST = 4;
    logic clk = 1'b0;
    logic arst, en, fifo_empty, fifo_r_en, out_valid, out_ready, out_last, busy;
    logic [7:0] fifo_rdata = 8'h00;
    logic [7:0] out_data;
    logic [1:0] beat_cnt;
`ifdef FIFO_DRAIN_PARITY_EN
    logic out_parity;
`endif
    logic [7:0] fmem [256];
    int wp = 0;
    int rp = 0;
    logic [7:0] exp_q[$];
    int nchk = 0, nfail = 0, nxfer = 0, mb = 0;

    typedef struct {
        int nwr;
        logic [7:0] base;
        logic rdy;
        logic en;
        int ncyc;
        int beat;
        int busy;
        int valid;
        int pops;
    } row_t;
    row_t tbl[7];

    fifo_drain #(.N(8), .BURST(BURST)) dut (
        .clk(clk), .arst(arst), .en(en), .fifo_empty(fifo_empty), .fifo_r_en(fifo_r_en),
        .fifo_rdata(fifo_rdata), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .beat_cnt(beat_cnt), .busy(busy)
`ifdef FIFO_DRAIN_PARITY_EN
        , .out_parity(out_parity)
`endif
    );

    always #5 clk = ~clk;
    assign fifo_empty = wp == rp;

    // One-cycle read latency FIFO model
    always @(posedge clk) begin
        if (fifo_r_en) begin
            fifo_rdata <= fmem[rp];
            rp <= rp + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic put(input logic [7:0] d);
        fmem[wp] = d;
        wp++;
        exp_q.push_back(d);
    endtask

    task automatic rebuild();
        exp_q.delete();
        for (int i = rp; i < wp; i++) exp_q.push_back(fmem[i]);
        mb = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mon();
        logic [7:0] e;
        @(negedge clk);
        if (!arst && out_valid && out_ready) begin
            nxfer++;
            if (exp_q.size() == 0) begin
                nchk++;
                nfail++;
                $display("FAIL xfer_extra: got %0h expected no transfer", out_data);
            end else begin
                e = exp_q.pop_front();
                chk("xfer_data", out_data, e);
                chk("xfer_last", out_last, mb == BURST - 1);
`ifdef FIFO_DRAIN_PARITY_EN
                chk("xfer_parity", out_parity, ^e);
`endif
            end
            mb = (mb + 1) % BURST;
        end
    endtask

    initial begin
        int first, lastv, rp0, x0, bt, n;
        logic [7:0] hold;
        logic held, found;
        tbl[0] = '{3, 8'h21, 1'b1, 1'b1, 10, 3, 1, 0, 3};
        tbl[1] = '{1, 8'h24, 1'b1, 1'b1, 6, 0, 1, 0, 1};
        tbl[2] = '{5, 8'h50, 1'b1, 1'b1, 12, 1, 1, 0, 5};
        tbl[3] = '{0, 8'h00, 1'b1, 1'b0, 6, 1, 0, 0, 0};
        tbl[4] = '{3, 8'h60, 1'b1, 1'b1, 10, 0, 1, 0, 3};
        tbl[5] = '{2, 8'h70, 1'b0, 1'b1, 6, 0, 1, 1, 2};
        tbl[6] = '{0, 8'h00, 1'b1, 1'b1, 6, 2, 1, 0, 0};

        arst = 1'b1;
        en = 1'b1;
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) put(8'(i));
        tick();
        tick();
        arst = 1'b0;
        en = 1'b0;
        rebuild();
        mon();
        chk("rst_r_en", fifo_r_en, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_data", out_data, 0);
        chk("rst_beat", beat_cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_no_pop", rp, 0);
        tick();

        en = 1'b1;
        first = -1;
        lastv = -1;
        x0 = nxfer;
        for (int i = 0; i < 16; i++) begin
            mon();
            if (i == 1) begin
                chk("stream_r_en", fifo_r_en, 1);
                chk("stream_busy", busy, 1);
            end
            if (out_valid) begin
                if (first < 0) first = i;
                lastv = i;
            end
            tick();
        end
        chk("stream_first", first, 3);
        chk("stream_lastv", lastv, 10);
        chk("stream_count", nxfer - x0, 8);
        mon();
        chk("stream_beat", beat_cnt, 0);
        tick();

        rp0 = rp;
        x0 = nxfer;
        held = 1'b0;
        hold = 8'h00;
        for (int i = 0; i < 12; i++) put(8'h10 + 8'(i));
        repeat (4) begin
            mon();
            tick();
        end
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mon();
            if (i == 0) begin
                hold = out_data;
                held = out_valid;
            end else if (out_data !== hold || !out_valid) held = 1'b0;
            if (i == 4) begin
                chk("bp_r_en", fifo_r_en, 0);
                chk("bp_credit", ((rp - rp0) - (nxfer - x0)) <= 2, 1);
            end
            tick();
        end
        chk("bp_hold", held, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
            mon();
            tick();
        end
        chk("bp_drained", exp_q.size(), 0);
        chk("bp_count", nxfer - x0, 12);

        foreach (tbl[k]) begin
            rp0 = rp;
            for (int j = 0; j < tbl[k].nwr; j++) put(tbl[k].base + 8'(j));
            en = tbl[k].en;
            out_ready = tbl[k].rdy;
            repeat (tbl[k].ncyc) begin
                mon();
                tick();
            end
            mon();
            chk($sformatf("row%0d_beat", k), beat_cnt, tbl[k].beat);
            chk($sformatf("row%0d_busy", k), busy, tbl[k].busy);
            chk($sformatf("row%0d_valid", k), out_valid, tbl[k].valid);
            chk($sformatf("row%0d_pops", k), rp - rp0, tbl[k].pops);
            tick();
        end

        rp0 = rp;
        x0 = nxfer;
        for (int i = 0; i < 4; i++) put(8'h31 + 8'(i));
        out_ready = 1'b0;
        repeat (4) begin
            mon();
            tick();
        end
        en = 1'b0;
        mon();
        chk("flush_full", out_valid, 1);
        tick();
        out_ready = 1'b1;
        mon();
        chk("flush_r_en", fifo_r_en, 0);
        tick();
        bt = -1;
        for (int i = 0; i < 6; i++) begin
            mon();
            if (!busy && bt < 0) bt = i;
            tick();
        end
        chk("flush_busy", bt >= 0 && bt <= 2, 1);
        chk("flush_pops", rp - rp0, 2);
        chk("flush_xfers", nxfer - x0, 2);
        en = 1'b1;
        repeat (10) begin
            mon();
            tick();
        end
        chk("flush_resume", exp_q.size(), 0);

        for (int i = 0; i < 6; i++) put(8'h41 + 8'(i));
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            mon();
            found = fifo_r_en;
            tick();
        end
        chk("mid_pop_seen", found, 1);
        arst = 1'b1;
        mon();
        tick();
        arst = 1'b0;
        mon();
        chk("mid_valid", out_valid, 0);
        chk("mid_beat", beat_cnt, 0);
        chk("mid_busy", busy, 0);
        rebuild();
        n = exp_q.size();
        x0 = nxfer;
        tick();
        repeat (20) begin
            mon();
            tick();
        end
        chk("mid_drained", exp_q.size(), 0);
        chk("mid_count", nxfer - x0, n);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
